weight_fifo_arr_control: RTL and testbench
==========================================

// Module: weight_fifo_arr_control
// PURPOSE
// Responder side of the weight_fifo_arr_en / weight_fifo_arr_done handshake issued by master_multip_control.
// On request, pops weight rows from the weight FIFO and shifts them into the systolic array's weight shift
// chain, zero-pads unused rows, pulses the array's weight latch, then reports done. Sits between the weight
// FIFO and the width_height x width_height MAC array.
// PARAMETERS
// width_height    16   array dimension; rows shifted per load
// TIMEOUT_CYCLES  256  consecutive empty-FIFO stall cycles before abort (WEIGHT_LOAD_TIMEOUT_EN only)
// PORTS
// clk                 in   1                    clock
// reset               in   1                    synchronous, active-high
// weight_fifo_arr_en  in   1                    load request from master (level)
// num_row_weight_mat  in   $clog2(width_height) valid weight rows minus 1 (0 -> 1 row, 15 -> 16 rows)
// fifo_empty          in   1                    weight FIFO empty
// fifo_rd_en          out  1                    pop one row; FIFO data is valid at the array input in the same cycle
// weight_shift        out  1                    array shifts its weight chain by one row
// weight_zero         out  1                    array shifts in an all-zero row (asserted only with weight_shift)
// weight_latch        out  1                    one-cycle: array copies shift chain into active weights
// weight_fifo_arr_done out 1                    load complete (level, four-phase)
// err                 out  1                    load aborted on FIFO timeout
// BEHAVIOUR
// - All outputs 0 on reset; state -> IDLE, counters -> 0. Reset mid-load abandons the load; no latch is issued.
// - States: IDLE, LOAD, LATCH, DONE. State register is updated on posedge clk; outputs decode the current state.
// - IDLE: when weight_fifo_arr_en=1, capture rows=num_row_weight_mat+1 and clear cnt. Enter LOAD next cycle.
// - LOAD: cnt counts shifts 0..width_height-1 and is $clog2(width_height)+1 bits wide.
//   - cnt < rows and !fifo_empty: fifo_rd_en=1, weight_shift=1, cnt++.
//   - cnt < rows and fifo_empty: stall. All outputs are 0 and cnt holds.
//   - cnt >= rows: weight_shift=1 and weight_zero=1, with no pop; cnt++.
//   - After the shift with cnt==width_height-1, go to LATCH.
//   - rows==width_height means no pad cycles. Total shift cycles are exactly width_height, excluding stalls.
// - LATCH: weight_latch=1 for exactly one cycle, then go to DONE.
// - DONE: weight_fifo_arr_done=1. Stay until weight_fifo_arr_en=0, then return to IDLE. done drops in the cycle after en falls.
// - The master drops en combinationally on done. Because of that, done is high for at least one cycle, and a new
//   request is accepted no earlier than the second cycle after done rises.
// - en falling during LOAD or LATCH aborts the load: return to IDLE next cycle with no latch and no done.
//   Rows already popped are lost; the master must refill.
// - Best case latency, en high to done high: 1 + width_height + 1 cycles (18 at default), plus any stall cycles.
// - fifo_rd_en and weight_zero are never both 1. The block never pops once cnt >= rows.
// CONFIGURATION
// WEIGHT_LOAD_TIMEOUT_EN defined:
// - A stall counter counts consecutive empty-FIFO stall cycles in LOAD and clears on any pop.
// - When it reaches TIMEOUT_CYCLES: go to DONE with err=1 and no latch.
// - err stays 1 while in DONE and clears on return to IDLE or on reset.
// WEIGHT_LOAD_TIMEOUT_EN undefined:
// - No stall counter exists; LOAD stalls indefinitely on an empty FIFO.
// - err is tied to 0.
// TESTING
// 1. num_row=15, FIFO holds 16 rows, en=1:
//    -> 16 cycles with fifo_rd_en=weight_shift=1, weight_zero never asserted;
//    -> weight_latch on cycle 18; done on 19; done drops the cycle after en falls.
// 2. num_row=3, FIFO holds 4 rows:
//    -> 4 pop+shift cycles, then 12 cycles with weight_shift=weight_zero=1 and fifo_rd_en=0;
//    -> exactly 1 latch, then done.
// 3. num_row=7; fifo_empty=1 for 5 cycles after the 2nd pop:
//    -> all outputs 0 for those 5 cycles, cnt holds;
//    -> 8 pops total, latch, done 5 cycles later than the unstalled case.
// 4. en falls after the 6th shift:
//    -> IDLE next cycle, no latch, done stays 0;
//    -> next en restarts from cnt=0 with newly captured num_row.
// 5. reset=1 during LATCH or DONE:
//    -> next cycle all outputs 0 and state IDLE;
//    -> a new request then completes normally.
// 6. (WEIGHT_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=8) num_row=2, FIFO empty after the 1st pop:
//    -> after 8 stall cycles, done=1 and err=1 with no latch;
//    -> err clears when en drops.

Source files
------------

// File: rtl/weight_fifo_arr_control.sv
// Weight loader: pops weight rows from the FIFO into the array shift chain, zero-pads, latches, reports done.
// Optional macro WEIGHT_LOAD_TIMEOUT_EN adds an empty-FIFO stall timeout that aborts to DONE with err.
module weight_fifo_arr_control #(
  parameter int width_height   = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            weight_fifo_arr_en,
  input  logic [$clog2(width_height)-1:0] num_row_weight_mat,
  input  logic                            fifo_empty,
  output logic                            fifo_rd_en,
  output logic                            weight_shift,
  output logic                            weight_zero,
  output logic                            weight_latch,
  output logic                            weight_fifo_arr_done,
  output logic                            err
);

  localparam int CW = $clog2(width_height) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, LATCH, DONE} state_t;

  state_t        state;
  logic [CW-1:0] rows;
  logic [CW-1:0] cnt;
  logic          in_load;
  logic          pad;
  logic          shift_now;
  logic          last;
  logic          timeout_hit;

  // Shift/pop are gated by en so an aborting cycle never consumes a row.
  assign in_load   = (state == LOAD) && weight_fifo_arr_en;
  assign pad       = (cnt >= rows);
  assign shift_now = in_load && (pad || !fifo_empty);
  assign last      = (cnt == CW'(width_height - 1));

  assign fifo_rd_en           = in_load && !pad && !fifo_empty;
  assign weight_shift         = shift_now;
  assign weight_zero          = in_load && pad;
  assign weight_latch         = (state == LATCH) && weight_fifo_arr_en;
  assign weight_fifo_arr_done = (state == DONE);

`ifdef WEIGHT_LOAD_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SW-1:0] stall_cnt;
  logic          stall;
  logic          err_q;

  assign stall       = in_load && !pad && fifo_empty;
  assign timeout_hit = stall && (stall_cnt == SW'(TIMEOUT_CYCLES - 1));
  assign err         = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state != LOAD || shift_now)
        stall_cnt <= '0;
      else if (stall)
        stall_cnt <= stall_cnt + SW'(1);

      if (timeout_hit)
        err_q <= 1'b1;
      else if (state != DONE || !weight_fifo_arr_en)
        err_q <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rows  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (weight_fifo_arr_en) begin
            rows  <= {1'b0, num_row_weight_mat} + CW'(1);
            cnt   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (!weight_fifo_arr_en) begin
            state <= IDLE;
          end else if (shift_now) begin
            cnt <= cnt + CW'(1);
            if (last)
              state <= LATCH;
          end else if (timeout_hit) begin
            state <= DONE;
          end
        end
        LATCH: state <= weight_fifo_arr_en ? DONE : IDLE;
        DONE: begin
          if (!weight_fifo_arr_en)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fifo_arr_control.sv
// Bench for weight_fifo_arr_control: table vectors, randomized loads against spec-level accounting, corner sequences.
module tb_weight_fifo_arr_control;

  localparam int W = 16;
`ifdef WEIGHT_LOAD_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] num_row;
  logic       fifo_empty;
  logic       rd_en, shift, zero, latch, done, err;

  int checks = 0;
  int errors = 0;

  weight_fifo_arr_control #(.width_height(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk                 (clk),
    .reset               (reset),
    .weight_fifo_arr_en  (en),
    .num_row_weight_mat  (num_row),
    .fifo_empty          (fifo_empty),
    .fifo_rd_en          (rd_en),
    .weight_shift        (shift),
    .weight_zero         (zero),
    .weight_latch        (latch),
    .weight_fifo_arr_done(done),
    .err                 (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int num;
    int stall_after;
    int stall_len;
    int exp_pops;
    int exp_zeros;
    int exp_lat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return {26'd0, rd_en, shift, zero, latch, done, err};
  endfunction

  // Runs one complete request and checks it against the load rules.
  // Returns the number of stall cycles the bench imposed while rows were still owed.
  task automatic run_load(input int num, input int sa, input int sl, input bit rnd,
                          input int exp_pops, input int exp_zeros, input int exp_lat_base,
                          output int stalls);
    int pops, zeros, latches, n, st, consec, bad;
    bit prev_shift, got_done;
    int rows;
    rows = num + 1;
    pops = 0; zeros = 0; latches = 0; n = 0; st = 0; consec = 0; bad = 0;
    stalls = 0; prev_shift = 0; got_done = 0;
    fifo_empty = 1'b0;
    num_row = 4'(num);
    en = 1'b1;
    while (n < 200 && !got_done) begin
      @(negedge clk);
      if (sa > 0 && pops == sa && st < sl) begin
        fifo_empty = 1'b1;
        st++;
      end else if (rnd && consec < 3 && $urandom_range(0, 3) == 0) begin
        fifo_empty = 1'b1;
      end else begin
        fifo_empty = 1'b0;
      end
      consec = fifo_empty ? consec + 1 : 0;
      #1;
      n++;
      if (err) bad++;
      if (done) begin
        got_done = 1;
      end else if (fifo_empty && pops < rows) begin
        stalls++;
        if (outs() != 0) bad++;
        prev_shift = 0;
      end else begin
        if (rd_en && fifo_empty) bad++;
        if (rd_en && zero) bad++;
        if (zero && !shift) bad++;
        if (rd_en && !shift) bad++;
        if (zero && pops < rows) bad++;
        if (rd_en && pops >= rows) bad++;
        if (latch && (!prev_shift || pops + zeros != W)) bad++;
        if (rd_en) pops++;
        if (zero) zeros++;
        if (latch) latches++;
        prev_shift = shift;
      end
    end
    check("done_reached", int'(got_done), 1);
    // Master drops en combinationally on done; done must fall the next cycle.
    en = 1'b0;
    fifo_empty = 1'b0;
    @(negedge clk); #1;
    check("done_drop", outs(), 0);
    check("pops", pops, exp_pops);
    check("zero_shifts", zeros, exp_zeros);
    check("latches", latches, 1);
    check("latency", n, exp_lat_base + stalls);
    check("protocol", bad, 0);
  endtask

  int s, shifts, bad, n, pops, latches;

  initial begin
    vecs[0] = '{15, 0, 0, 16, 0, 18};
    vecs[1] = '{3, 0, 0, 4, 12, 18};
    vecs[2] = '{7, 2, 5, 8, 8, 23};
    vecs[3] = '{0, 1, 3, 1, 15, 18};
    vecs[4] = '{15, 15, 4, 16, 0, 22};

    reset = 1'b1; en = 1'b0; num_row = '0; fifo_empty = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", outs(), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;

    for (int i = 0; i < 5; i++) begin
      run_load(vecs[i].num, vecs[i].stall_after, vecs[i].stall_len, 1'b0,
               vecs[i].exp_pops, vecs[i].exp_zeros, 18, s);
      check("table_stalls", 18 + s, vecs[i].exp_lat);
    end

    for (int i = 0; i < 20; i++) begin
      int nr;
      nr = $urandom_range(0, W - 1);
      run_load(nr, 0, 0, 1'b1, nr + 1, W - 1 - nr, 18, s);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Abort: en falls after the 6th shift.
    num_row = 4'd9; en = 1'b1; fifo_empty = 1'b0; shifts = 0; n = 0;
    while (shifts < 6 && n < 40) begin
      @(negedge clk); #1; n++;
      if (shift) shifts++;
    end
    check("abort_shifts", shifts, 6);
    @(negedge clk);
    en = 1'b0;
    #1;
    check("abort_cycle_outs", outs(), 0);
    bad = 0;
    repeat (25) begin
      @(negedge clk); #1;
      if (outs() != 0) bad++;
    end
    check("abort_idle", bad, 0);
    run_load(1, 0, 0, 1'b0, 2, 14, 18, s);

    // Reset during LATCH.
    num_row = 4'd3; en = 1'b1; n = 0; latches = 0;
    while (latches == 0 && n < 40) begin
      @(negedge clk); #1; n++;
      if (latch) latches++;
    end
    check("reached_latch", latches, 1);
    reset = 1'b1;
    @(negedge clk); #1;
    check("reset_in_latch", outs(), 0);
    reset = 1'b0; en = 1'b0;
    @(negedge clk); #1;
    check("after_reset_latch", outs(), 0);
    run_load(5, 0, 0, 1'b0, 6, 10, 18, s);

    // Reset during DONE.
    num_row = 4'd15; en = 1'b1; n = 0;
    while (!done && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check("reached_done", int'(done), 1);
    reset = 1'b1;
    @(negedge clk); #1;
    check("reset_in_done", outs(), 0);
    reset = 1'b0; en = 1'b0;
    @(negedge clk); #1;
    check("after_reset_done", outs(), 0);
    run_load(10, 3, 2, 1'b0, 11, 5, 18, s);
    check("post_reset_stalls", s, 2);

`ifdef WEIGHT_LOAD_TIMEOUT_EN
    // Timeout: FIFO runs dry after the first pop.
    num_row = 4'd2; en = 1'b1; fifo_empty = 1'b0; n = 0; pops = 0; latches = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      fifo_empty = (pops >= 1);
      #1; n++;
      if (rd_en) pops++;
      if (latch) latches++;
    end
    check("to_done_cycle", n, 10);
    check("to_err", int'(err), 1);
    check("to_pops", pops, 1);
    check("to_latches", latches, 0);
    en = 1'b0; fifo_empty = 1'b0;
    @(negedge clk); #1;
    check("to_err_clear", int'(err), 0);
    check("to_done_clear", int'(done), 0);
    run_load(2, 0, 0, 1'b0, 3, 13, 18, s);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
